// File: rtl/hamming_wr_encoder_pkg.sv
// Shared Hamming SECDED helpers for the write encoder, decoder and bank checker.
package hamming_wr_encoder_pkg;

  // Bank select occupies the top address bits.
  localparam int SEL_W = 2;

  function automatic int parity_bits(input int dw);
    return $clog2(dw) + 1;
  endfunction

  // Codeword length without the overall parity bit.
  function automatic int encoded_word(input int dw);
    return dw + parity_bits(dw);
  endfunction

  function automatic logic is_pow2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Data bit index carried at a codeword position, -1 at parity positions.
  function automatic int data_idx(input int pos);
    int n;
    n = 0;
    if (is_pow2(pos)) return -1;
    for (int q = 1; q < pos; q++) begin
      if (!is_pow2(q)) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/hamming_wr_encoder_secded.sv
// Combinational Hamming SECDED encoder; code bit index equals Hamming position.
module hamming_secded_enc
  import hamming_wr_encoder_pkg::*;
#(
  parameter  int DATA_WIDTH   = 8,
  localparam int PARITY_BITS  = parity_bits(DATA_WIDTH),
  localparam int ENCODED_WORD = encoded_word(DATA_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0]   data,
  output logic [ENCODED_WORD+1:1] code
);

  // Positions covered by the parity bit at position p (p is a power of two).
  function automatic logic [ENCODED_WORD:1] cover_mask(input int p);
    logic [ENCODED_WORD:1] m;
    m = '0;
    for (int q = 1; q <= ENCODED_WORD; q++) m[q] = ((q & p) != 0);
    return m;
  endfunction

  // Data bits scattered to their positions; parity and unused slots read 0.
  logic [ENCODED_WORD:1] dmap;

  for (genvar p = 1; p <= ENCODED_WORD; p++) begin : g_map
    localparam int IDX = data_idx(p);
    if (IDX >= 0 && IDX < DATA_WIDTH) begin : g_dat
      assign dmap[p] = data[IDX];
    end else begin : g_zero
      assign dmap[p] = 1'b0;
    end
  end

  // Even parity at power-of-two positions, data passes through elsewhere.
  for (genvar p = 1; p <= ENCODED_WORD; p++) begin : g_code
    if (is_pow2(p) && p < (1 << PARITY_BITS)) begin : g_par
      assign code[p] = ^(dmap & cover_mask(p));
    end else begin : g_dat
      assign code[p] = dmap[p];
    end
  end

  assign code[ENCODED_WORD+1] = ^code[ENCODED_WORD:1];

endmodule

// File: rtl/hamming_wr_encoder.sv
// Two-stage write-path encoder: register raw word, SECDED encode, present to demux.
module hamming_wr_encoder
  import hamming_wr_encoder_pkg::*;
#(
  parameter  int DATA_WIDTH   = 8,
  parameter  int ADDR_WIDTH   = 6,
  parameter  int CNT_WIDTH    = 16,
  localparam int ENCODED_WORD = encoded_word(DATA_WIDTH)
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [DATA_WIDTH-1:0]       i_data,
  input  logic [ADDR_WIDTH-1:0]       i_addr,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [ENCODED_WORD+1:1]     o_code,
  output logic [SEL_W-1:0]            o_sel,
  output logic [ADDR_WIDTH-SEL_W-1:0] o_bank_addr,
  output logic [CNT_WIDTH-1:0]        o_wr_count
);

  logic                    a_vld, b_vld;
  logic                    b_load, accept;
  logic [DATA_WIDTH-1:0]   a_data;
  logic [ADDR_WIDTH-1:0]   a_addr;
  logic [ENCODED_WORD+1:1] enc_code;

  // Stage A may refill whenever stage B drains it this cycle (i_ready path is combinational).
  assign b_load  = !b_vld || i_ready;
  assign o_ready = !a_vld || b_load;
  assign accept  = i_valid && o_ready;
  assign o_valid = b_vld;

  // Stage A occupancy: fill on accept, empty when its word moves to B.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    a_vld <= 1'b0;
    else if (accept) a_vld <= 1'b1;
    else if (b_load) a_vld <= 1'b0;
  end

  // Stage A payload; content is don't-care while a_vld is low.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      a_data <= i_data;
      a_addr <= i_addr;
    end
  end

  hamming_secded_enc #(.DATA_WIDTH(DATA_WIDTH)) u_enc (
    .data (a_data),
    .code (enc_code)
  );

  // Stage B: capture codeword and routing fields, hold them while stalled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      b_vld       <= 1'b0;
      o_code      <= '0;
      o_sel       <= '0;
      o_bank_addr <= '0;
    end else if (b_load) begin
      b_vld <= a_vld;
      if (a_vld) begin
        o_code      <= enc_code;
        o_sel       <= a_addr[ADDR_WIDTH-1 -: SEL_W];
        o_bank_addr <= a_addr[ADDR_WIDTH-SEL_W-1:0];
      end
    end
  end

  // Completed output handshakes; wraps naturally at 2^CNT_WIDTH.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)              o_wr_count <= '0;
    else if (b_vld && i_ready) o_wr_count <= o_wr_count + 1'b1;
  end

endmodule

// File: tb/tb_hamming_wr_encoder.sv
`timescale 1ns/1ps
module tb_hamming_wr_encoder;
  localparam int DW = 8;
  localparam int AW = 6;
  localparam int CW = 16;
  localparam int EW = 12;
  localparam int XW = EW + 1 + 2 + 4;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic          i_ready = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic [AW-1:0] i_addr = '0;
  logic          o_ready, o_valid;
  logic [EW+1:1] o_code;
  logic [1:0]    o_sel;
  logic [3:0]    o_bank_addr;
  logic [CW-1:0] o_wr_count;

  int total = 0;
  int bad = 0;
  logic [CW-1:0] exp_cnt = '0;
  logic [XW-1:0] sb[$];

  hamming_wr_encoder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_addr(i_addr), .o_valid(o_valid), .i_ready(i_ready),
    .o_code(o_code), .o_sel(o_sel), .o_bank_addr(o_bank_addr), .o_wr_count(o_wr_count)
  );

  always #5 i_clk = ~i_clk;

  // Reference: place data at non-power-of-two positions, then pick parity bits so the
  // XOR of all set positions is zero; overall bit makes total parity even.
  function automatic logic [EW+1:1] ref_encode(input logic [DW-1:0] d);
    logic [EW+1:1] c;
    int s, di;
    c = '0; s = 0; di = 0;
    for (int p = 1; p <= EW; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (di < DW && d[di]) begin c[p] = 1'b1; s ^= p; end
        di++;
      end
    end
    for (int k = 0; k < 4; k++) if (s[k]) c[1 << k] = 1'b1;
    c[EW+1] = ^c[EW:1];
    return c;
  endfunction

  function automatic logic [XW-1:0] mk(input logic [DW-1:0] d, input logic [AW-1:0] a);
    return {ref_encode(d), a[5:4], a[3:0]};
  endfunction

  task automatic test_reset();
    i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", o_valid); end
    total++; if (o_code !== '0) begin bad++; $display("FAIL rst_code got=%h want=0", o_code); end
    total++; if (o_sel !== 2'b00 || o_bank_addr !== 4'h0) begin bad++; $display("FAIL rst_route got=%b/%h want=0/0", o_sel, o_bank_addr); end
    total++; if (o_wr_count !== '0) begin bad++; $display("FAIL rst_count got=%0d want=0", o_wr_count); end
    i_rst_n = 1'b1;
    exp_cnt = '0;
    @(negedge i_clk);
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", o_ready); end
  endtask

  task automatic test_directed(input string nm, input logic [DW-1:0] d, input logic [AW-1:0] a,
                               input logic [EW+1:1] ec, input logic [1:0] es, input logic [3:0] eb);
    i_ready = 1'b1; i_valid = 1'b1; i_data = d; i_addr = a;
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_data = 8'($urandom); i_addr = 6'($urandom);
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL %s_early got=%b want=0", nm, o_valid); end
    @(posedge i_clk); #1;
    total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL %s_valid got=%b want=1", nm, o_valid); end
    total++; if (o_code !== ec) begin bad++; $display("FAIL %s_code got=%h want=%h", nm, o_code, ec); end
    total++; if (o_sel !== es || o_bank_addr !== eb)
      begin bad++; $display("FAIL %s_route got=%b/%h want=%b/%h", nm, o_sel, o_bank_addr, es, eb); end
    @(posedge i_clk); #1;
    exp_cnt++;
    total++; if (o_wr_count !== exp_cnt || o_valid !== 1'b0)
      begin bad++; $display("FAIL %s_count got=%0d/%b want=%0d/0", nm, o_wr_count, o_valid, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [XW-1:0] e;
    logic [CW-1:0] want;
    int sent, got, first, last;
    sent = 0; got = 0; first = -1; last = -1;
    want = exp_cnt + 16'd4;
    sb.delete();
    i_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      i_valid = (sent < 4); i_data = 8'($urandom); i_addr = 6'($urandom);
      @(negedge i_clk);
      total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready cyc=%0d got=%b want=1", cyc, o_ready); end
      if (o_valid && i_ready) begin
        got++; if (first < 0) first = cyc; last = cyc;
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL b2b_extra got=%h want=none", o_code); end
        else begin
          e = sb.pop_front();
          if ({o_code, o_sel, o_bank_addr} !== e) begin bad++; $display("FAIL b2b_word got=%h want=%h", {o_code, o_sel, o_bank_addr}, e); end
        end
      end
      if (i_valid && o_ready) begin sb.push_back(mk(i_data, i_addr)); sent++; end
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    total++; if (got != 4 || last - first != 3)
      begin bad++; $display("FAIL b2b_stream got=%0d words span=%0d want=4 span=3", got, last - first); end
    total++; if (o_wr_count !== want) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", o_wr_count, want); end
    exp_cnt = want;
  endtask

  task automatic test_stall();
    logic [DW-1:0] wd[3];
    logic [AW-1:0] wa[3];
    logic [XW-1:0] e;
    int idx, got;
    idx = 0; got = 0;
    sb.delete();
    for (int i = 0; i < 3; i++) begin wd[i] = 8'($urandom); wa[i] = 6'($urandom); end
    for (int cyc = 0; cyc < 20; cyc++) begin
      i_ready = (cyc >= 6);
      i_valid = (idx < 3);
      i_data = wd[(idx < 3) ? idx : 0]; i_addr = wa[(idx < 3) ? idx : 0];
      @(negedge i_clk);
      if (cyc == 4) begin
        total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL stall_ready got=%b want=0", o_ready); end
        total++; if (idx != 2) begin bad++; $display("FAIL stall_accepted got=%0d want=2", idx); end
      end
      if (cyc == 3 || cyc == 5) begin
        total++; if (o_valid !== 1'b1 || o_code !== ref_encode(wd[0]))
          begin bad++; $display("FAIL stall_hold cyc=%0d got=%b/%h want=1/%h", cyc, o_valid, o_code, ref_encode(wd[0])); end
      end
      if (o_valid && i_ready) begin
        got++; exp_cnt++;
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL stall_extra got=%h want=none", o_code); end
        else begin
          e = sb.pop_front();
          if ({o_code, o_sel, o_bank_addr} !== e) begin bad++; $display("FAIL stall_word got=%h want=%h", {o_code, o_sel, o_bank_addr}, e); end
        end
      end
      if (i_valid && o_ready) begin sb.push_back(mk(wd[idx], wa[idx])); idx++; end
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    total++; if (got != 3 || idx != 3) begin bad++; $display("FAIL stall_drain got=%0d in/%0d out want=3/3", idx, got); end
    total++; if (o_wr_count !== exp_cnt) begin bad++; $display("FAIL stall_count got=%0d want=%0d", o_wr_count, exp_cnt); end
  endtask

  task automatic test_random();
    logic [XW-1:0] e;
    logic [EW+1:1] f;
    int syn, pos;
    bit hold;
    hold = 1'b0;
    sb.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!hold) begin
        i_valid = (cyc < 360) && ($urandom_range(0, 9) < 7);
        i_data = 8'($urandom); i_addr = 6'($urandom);
      end
      i_ready = (cyc >= 360) || ($urandom_range(0, 9) < 6);
      @(negedge i_clk);
      total++; if (o_wr_count !== exp_cnt) begin bad++; $display("FAIL rnd_count cyc=%0d got=%0d want=%0d", cyc, o_wr_count, exp_cnt); end
      if (o_valid && i_ready) begin
        exp_cnt++;
        total++;
        if (sb.size() == 0) begin bad++; $display("FAIL rnd_extra got=%h want=none", o_code); end
        else begin
          e = sb.pop_front();
          if ({o_code, o_sel, o_bank_addr} !== e) begin bad++; $display("FAIL rnd_word got=%h want=%h", {o_code, o_sel, o_bank_addr}, e); end
        end
        pos = $urandom_range(1, EW);
        f = o_code; f[pos] = ~f[pos];
        syn = 0;
        for (int p = 1; p <= EW; p++) if (f[p]) syn ^= p;
        total++; if (syn != pos || (^f) !== 1'b1)
          begin bad++; $display("FAIL rnd_syndrome got=%0d par=%b want=%0d par=1", syn, ^f, pos); end
      end
      if (i_valid && o_ready) begin sb.push_back(mk(i_data, i_addr)); hold = 1'b0; end
      else hold = i_valid;
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    total++; if (sb.size() != 0) begin bad++; $display("FAIL rnd_drain left=%0d want=0", sb.size()); end
  endtask

  task automatic test_reset_midflight();
    i_ready = 1'b0; i_valid = 1'b1;
    repeat (2) begin
      i_data = 8'($urandom); i_addr = 6'($urandom);
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    total++; if (o_valid !== 1'b1 || o_ready !== 1'b0)
      begin bad++; $display("FAIL mid_full got=%b/%b want=1/0", o_valid, o_ready); end
    #2; i_rst_n = 1'b0; #1;
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b want=0", o_valid); end
    total++; if (o_wr_count !== '0) begin bad++; $display("FAIL mid_count got=%0d want=0", o_wr_count); end
    exp_cnt = '0; sb.delete();
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1; i_ready = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge i_clk);
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL mid_stale cyc=%0d got=%b want=0", cyc, o_valid); end
      @(posedge i_clk); #1;
    end
    total++; if (o_wr_count !== '0) begin bad++; $display("FAIL mid_count_after got=%0d want=0", o_wr_count); end
  endtask

  initial begin
    test_reset();
    test_directed("zero", 8'h00, 6'h00, 13'h0000, 2'b00, 4'h0);
    test_directed("one",  8'h01, 6'h25, 13'h1007, 2'b10, 4'h5);
    test_directed("ones", 8'hFF, 6'h3F, 13'h0F77, 2'b11, 4'hF);
    test_back_to_back();
    test_stall();
    test_random();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
